// File: rtl/ip_stats_reader.sv
// ip_stats_reader
//   Read-side counterpart of the free-running stats counters. A snapshot
//   request captures all NUM_STATS counters on one edge. The captured words
//   are then streamed out one per accepted valid/ready handshake.
//
//   Optional feature macro: IP_STATS_RD_DELTA_EN
//     defined   : each word is snap[k] - prev[k] (mod 2**STATS_WIDTH), the
//                 increment since the last fully read snapshot
//     undefined : each word is the raw snap[k]; no prev registers exist
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   snapReq    in   single-cycle snapshot request
//   statsIn    in   flattened counters, counter k at [k*STATS_WIDTH +: STATS_WIDTH]
//   rdReady    in   downstream accepts the current word
//   rdValid    out  rdData / rdIndex / rdLast are valid
//   rdData     out  snapshot word (raw value or delta)
//   rdIndex    out  counter index of rdData
//   rdLast     out  high with the word for index NUM_STATS-1
//   busy       out  a snapshot is being streamed
//   donePulse  out  one-cycle pulse after the last word is accepted
//   snapMiss   out  sticky: a snapReq arrived while busy
module ip_stats_reader #(
    parameter int unsigned NUM_STATS   = 4,
    parameter int unsigned STATS_WIDTH = 8,
    parameter int unsigned IDX_WIDTH   = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             snapReq,
    input  logic [NUM_STATS*STATS_WIDTH-1:0] statsIn,
    input  logic                             rdReady,
    output logic                             rdValid,
    output logic [STATS_WIDTH-1:0]           rdData,
    output logic [IDX_WIDTH-1:0]             rdIndex,
    output logic                             rdLast,
    output logic                             busy,
    output logic                             donePulse,
    output logic                             snapMiss
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_STATS - 1);

    state_t                 state;
    logic [STATS_WIDTH-1:0] snap [NUM_STATS];
`ifdef IP_STATS_RD_DELTA_EN
    logic [STATS_WIDTH-1:0] prev [NUM_STATS];
`endif

    logic [IDX_WIDTH-1:0]   next_idx;
    logic [STATS_WIDTH-1:0] first_word;
    logic [STATS_WIDTH-1:0] next_word;

    // rdData is registered, so the word for the following index is
    // prepared ahead of the edge that advances the index. prev[next_idx]
    // is untouched by the accept of the current index.
    always_comb begin
        next_idx = rdIndex + IDX_WIDTH'(1);
`ifdef IP_STATS_RD_DELTA_EN
        first_word = statsIn[0 +: STATS_WIDTH] - prev[0];
        next_word  = snap[next_idx] - prev[next_idx];
`else
        first_word = statsIn[0 +: STATS_WIDTH];
        next_word  = snap[next_idx];
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rdValid   <= 1'b0;
            rdData    <= '0;
            rdIndex   <= '0;
            rdLast    <= 1'b0;
            busy      <= 1'b0;
            donePulse <= 1'b0;
            snapMiss  <= 1'b0;
            for (int unsigned k = 0; k < NUM_STATS; k++) begin
                snap[k] <= '0;
`ifdef IP_STATS_RD_DELTA_EN
                prev[k] <= '0;
`endif
            end
        end else begin
            donePulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (snapReq) begin
                        for (int unsigned k = 0; k < NUM_STATS; k++) begin
                            snap[k] <= statsIn[k*STATS_WIDTH +: STATS_WIDTH];
                        end
                        snapMiss <= 1'b0;
                        rdIndex  <= '0;
                        rdData   <= first_word;
                        rdLast   <= 1'b0;
                        rdValid  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (snapReq) begin
                        snapMiss <= 1'b1;
                    end
                    if (rdReady) begin
`ifdef IP_STATS_RD_DELTA_EN
                        prev[rdIndex] <= snap[rdIndex];
`endif
                        if (rdIndex == LAST_IDX) begin
                            state     <= IDLE;
                            rdValid   <= 1'b0;
                            busy      <= 1'b0;
                            rdLast    <= 1'b0;
                            donePulse <= 1'b1;
                        end else begin
                            rdIndex <= next_idx;
                            rdData  <= next_word;
                            rdLast  <= (next_idx == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ip_stats_reader.sv
// tb_ip_stats_reader
//   Self-checking bench for ip_stats_reader (NUM_STATS=4, STATS_WIDTH=8).
//   A transaction-level reference model tracks the expected snapshot,
//   read position, prev values, done pulse and miss flag.
module tb_ip_stats_reader;

    logic        clock;
    logic        reset;
    logic        snapReq;
    logic [31:0] statsIn;
    logic        rdReady;
    logic        rdValid;
    logic [7:0]  rdData;
    logic [1:0]  rdIndex;
    logic        rdLast;
    logic        busy;
    logic        donePulse;
    logic        snapMiss;

    ip_stats_reader #(
        .NUM_STATS  (4),
        .STATS_WIDTH(8),
        .IDX_WIDTH  (2)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .snapReq  (snapReq),
        .statsIn  (statsIn),
        .rdReady  (rdReady),
        .rdValid  (rdValid),
        .rdData   (rdData),
        .rdIndex  (rdIndex),
        .rdLast   (rdLast),
        .busy     (busy),
        .donePulse(donePulse),
        .snapMiss (snapMiss)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model
    int unsigned m_snap [4];
    int unsigned m_prev [4];
    bit          m_busy;
    int unsigned m_idx;
    bit          m_done;
    bit          m_miss;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word(input int unsigned k);
`ifdef IP_STATS_RD_DELTA_EN
        return (m_snap[k] - m_prev[k]) & 32'hFF;
`else
        return m_snap[k];
`endif
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_snap[k] = 0;
            m_prev[k] = 0;
        end
        m_busy = 1'b0;
        m_idx  = 0;
        m_done = 1'b0;
        m_miss = 1'b0;
    endtask

    task automatic compare_outputs();
        check("rdValid",   32'(rdValid),   32'(m_busy));
        check("busy",      32'(busy),      32'(m_busy));
        check("donePulse", 32'(donePulse), 32'(m_done));
        check("snapMiss",  32'(snapMiss),  32'(m_miss));
        if (m_busy) begin
            check("rdIndex", 32'(rdIndex), m_idx);
            check("rdData",  32'(rdData),  word(m_idx));
            check("rdLast",  32'(rdLast),  32'(m_idx == 3));
        end
    endtask

    // Called at a negedge: drive inputs, advance the model over the
    // coming rising edge, then compare at the following negedge.
    task automatic step(input bit req, input logic [31:0] stats, input bit ready);
        snapReq = req;
        statsIn = stats;
        rdReady = ready;
        m_done  = 1'b0;
        if (m_busy) begin
            if (req) m_miss = 1'b1;
            if (ready) begin
                m_prev[m_idx] = m_snap[m_idx];
                if (m_idx == 3) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end else begin
                    m_idx++;
                end
            end
        end else if (req) begin
            for (int k = 0; k < 4; k++) m_snap[k] = (stats >> (8 * k)) & 32'hFF;
            m_idx  = 0;
            m_miss = 1'b0;
            m_busy = 1'b1;
        end
        @(posedge clock);
        @(negedge clock);
        compare_outputs();
    endtask

    // Asynchronous reset applied between edges; outputs must clear at once.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst_rdValid",   32'(rdValid),   0);
        check("rst_busy",      32'(busy),      0);
        check("rst_donePulse", 32'(donePulse), 0);
        check("rst_snapMiss",  32'(snapMiss),  0);
        check("rst_rdData",    32'(rdData),    0);
        check("rst_rdIndex",   32'(rdIndex),   0);
        check("rst_rdLast",    32'(rdLast),    0);
        model_reset();
        snapReq = 1'b0;
        rdReady = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        compare_outputs();
    endtask

    initial begin
        reset   = 1'b0;
        snapReq = 1'b0;
        statsIn = '0;
        rdReady = 1'b0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        do_reset();

        // 1: basic stream at one word per cycle
        step(1'b1, 32'h44332211, 1'b1);
        check("t1_word0", 32'(rdData), 32'h11);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        check("t1_last", 32'(rdLast), 1);
        step(1'b0, 32'h0, 1'b1);
        check("t1_done", 32'(donePulse), 1);
        step(1'b0, 32'h0, 1'b0);

        // 2: stall at idx1 while counters move
        do_reset();
        step(1'b1, 32'h44332211, 1'b1);
        step(1'b0, $urandom, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, $urandom, 1'b0);
        check("t2_hold_data", 32'(rdData), 32'h22);
        check("t2_hold_idx",  32'(rdIndex), 1);
        for (int i = 0; i < 4; i++) step(1'b0, $urandom, 1'b1);

        // 3: snapReq while busy at idx2 is missed; next accepted one clears it
        step(1'b1, 32'hA3A2A1A0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h12345678, 1'b0);
        check("t3_miss", 32'(snapMiss), 1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h0F0E0D0C, 1'b0);
        check("t3_miss_clr", 32'(snapMiss), 0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);

        // 4: counter 0 wraps between snapshots
        do_reset();
        step(1'b1, 32'h000000F0, 1'b1);
        check("t4_first", 32'(rdData), 32'hF0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h00000010, 1'b1);
`ifdef IP_STATS_RD_DELTA_EN
        check("t4_second", 32'(rdData), 32'h20);
`else
        check("t4_second", 32'(rdData), 32'h10);
`endif
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);

        // 5: reset mid-stream at idx2, then a fresh snapshot from idx0
        step(1'b1, 32'h55667788, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        do_reset();
        step(1'b1, 32'h01020304, 1'b1);
        check("t5_idx0", 32'(rdIndex), 0);
        check("t5_word0", 32'(rdData), 32'h04);

        // 6: snapReq in the donePulse cycle is accepted
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'hDEADBEEF, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        check("t6_done", 32'(donePulse), 1);
        step(1'b1, 32'hCAFEF00D, 1'b0);
        check("t6_valid", 32'(rdValid), 1);
        check("t6_miss",  32'(snapMiss), 0);
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);

        // Random traffic with occasional mid-stream resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 5) == 0), $urandom, ($urandom_range(0, 3) != 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
